// File: rtl/mul_iter_radix_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
// The master drives requests; the multiplier connects through the slave modport.
interface mul_iter_radix_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      mul_opcode;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            abort;
    logic [XLEN-1:0] result;
    logic            done;
    logic            busy;

    modport master (
        output start, mul_opcode, operand1, operand2, abort,
        input  result, done, busy
    );

    modport slave (
        input  start, mul_opcode, operand1, operand2, abort,
        output result, done, busy
    );
endinterface

// File: rtl/mul_iter_radix.sv
// Iterative sign-magnitude multiplier for MUL/MULH/MULHSU/MULHU, BITS_PER_CYCLE bits per CALC cycle.
// Optional early exit on an exhausted multiplier: define MUL_ITER_ZERO_SKIP_EN.
module mul_iter_radix #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic             clk,
    input logic             rst_n,
    mul_iter_radix_if.slave bus
);
    localparam int NITER = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(NITER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] pp;
    logic [XLEN:0]     mplier;
    logic [XLEN:0]     mplier_next;
    logic              neg;
    logic              high_half;
    logic              calc_last;
    logic              a_neg_in;
    logic              b_neg_in;
    logic [XLEN:0]     op1_abs;
    logic [XLEN:0]     op2_abs;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              busy_q;

    // Magnitudes are formed one bit wider so that |most-negative| is exact.
    always_comb begin
        a_neg_in = bus.operand1[XLEN-1] &&
                   (bus.mul_opcode == OP_MULH || bus.mul_opcode == OP_MULHSU);
        b_neg_in = bus.operand2[XLEN-1] && (bus.mul_opcode == OP_MULH);
        op1_abs  = {1'b0, bus.operand1};
        op2_abs  = {1'b0, bus.operand2};
        if (a_neg_in)
            op1_abs = -{1'b1, bus.operand1};
        if (b_neg_in)
            op2_abs = -{1'b1, bus.operand2};
    end

    // mcand is pre-shifted each cycle, so the partial product lands in place.
    assign pp          = mcand * (2*XLEN)'(mplier[BITS_PER_CYCLE-1:0]);
    assign mplier_next = mplier >> BITS_PER_CYCLE;

`ifdef MUL_ITER_ZERO_SKIP_EN
    assign calc_last = (cnt == CNT_W'(NITER - 1)) || (mplier_next == '0);
`else
    assign calc_last = (cnt == CNT_W'(NITER - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mcand     <= '0;
            prod      <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            high_half <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy still high here means this is the done cycle: refuse start.
                    if (busy_q) begin
                        busy_q <= 1'b0;
                    end else if (bus.start && !bus.abort) begin
                        state     <= S_CALC;
                        busy_q    <= 1'b1;
                        mcand     <= (2*XLEN)'(op1_abs);
                        mplier    <= op2_abs;
                        neg       <= a_neg_in ^ b_neg_in;
                        high_half <= (bus.mul_opcode != OP_MUL);
                        prod      <= '0;
                        cnt       <= '0;
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        prod   <= prod + pp;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier_next;
                        cnt    <= cnt + CNT_W'(1);
                        if (calc_last)
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (neg)
                            prod <= -prod;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    result_q <= high_half ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                    done_q   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_mul_iter_radix.sv
// Scoreboard bench for mul_iter_radix (XLEN=32, one bit per cycle): directed vectors,
// latency, busy, abort, back-to-back and mid-operation reset.
module tb_mul_iter_radix;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [XLEN-1:0] exp_q[$];
    string           name_q[$];
    logic [XLEN-1:0] last_result;
    logic [XLEN-1:0] mon_exp;
    string           mon_name;

    mul_iter_radix_if #(.XLEN(XLEN)) bus ();

    mul_iter_radix #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Edges from the start-sampling edge to the edge that raises done.
    function automatic int expLatency(input logic [1:0] op, input logic [XLEN-1:0] b);
        logic [XLEN-1:0] m;
        int              hi;
        m  = (op == 2'b01 && b[XLEN-1]) ? -b : b;
        hi = 0;
        for (int i = 0; i < XLEN; i++)
            if (m[i]) hi = i;
`ifdef MUL_ITER_ZERO_SKIP_EN
        return hi + 3;
`else
        return XLEN + 2 + (hi * 0);
`endif
    endfunction

    // Monitor: every done pulse is matched against the next expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", {63'b0, bus.done}, 64'd0);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                checkOutput(mon_name, {32'b0, bus.result}, {32'b0, mon_exp});
            end
        end
    end

    // mode 0: plain; mode 1: start pulse with other operands mid-CALC; mode 2: abort in DONE
    task automatic applyStimulus(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [XLEN-1:0] exp, input string name, input int mode);
        int edges;
        int busy_low;
        int lat;
        lat = expLatency(op, b);
        @(negedge clk);
        bus.mul_opcode = op;
        bus.operand1   = a;
        bus.operand2   = b;
        bus.start      = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges     = 0;
        busy_low  = bus.busy ? 0 : 1;
        while (!bus.done && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (!bus.busy) busy_low++;
            bus.start = (mode == 1 && edges == 2);
            if (mode == 1 && edges == 2) begin
                bus.operand1 = 32'h9;
                bus.operand2 = 32'h9;
            end
            bus.abort = (mode == 2 && edges == lat - 1);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        checkOutput({name, "_latency"}, 64'(edges), 64'(lat));
        checkOutput({name, "_busy_low"}, 64'(busy_low), 64'd0);
        @(posedge clk);
        #1;
        last_result = exp;
    endtask

    initial begin
        int n;
        int done_seen;
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int done_seen;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.mul_opcode = 2'b00;
        bus.operand1   = '0;
        bus.operand2   = '0;
        last_result    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", {32'b0, bus.result}, 64'd0);
        checkOutput("reset_done", {63'b0, bus.done}, 64'd0);
        checkOutput("reset_busy", {63'b0, bus.busy}, 64'd0);
        rst_n = 1'b1;

        applyStimulus(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul_7x6", 1);
        applyStimulus(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_minmin", 0);
        applyStimulus(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_ff", 0);
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff", 0);
        applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, "mul_m3x5", 0);
        applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, "mulh_m3x5", 0);
        applyStimulus(2'b01, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, "mulh_maxmin", 0);
        applyStimulus(2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, "mulhsu_min", 0);
        applyStimulus(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1m1", 0);
        applyStimulus(2'b00, 32'h12345678, 32'h00000000, 32'h00000000, "mul_by_zero", 0);
        applyStimulus(2'b00, 32'h12345678, 32'h00000100, 32'h34567800, "mul_by_100", 0);
        applyStimulus(2'b11, 32'h00000003, 32'h00000004, 32'h00000000, "mulhu_small_abort_done", 2);

        // Abort ten cycles into a MUL: nothing is reported, result is kept.
        @(negedge clk);
        bus.mul_opcode = 2'b00;
        bus.operand1   = 32'h00001234;
        bus.operand2   = 32'h80000001;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        checkOutput("abort_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("abort_result_kept", {32'b0, bus.result}, {32'b0, last_result});
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        checkOutput("abort_no_done", 64'(done_seen), 64'd0);
        applyStimulus(2'b00, 32'd3, 32'd5, 32'h0000000F, "mul_3x5_after_abort", 0);

        // Start held through the done cycle is ignored there and accepted next cycle.
        @(negedge clk);
        bus.mul_opcode = 2'b00;
        bus.operand1   = 32'd2;
        bus.operand2   = 32'd3;
        bus.start      = 1'b1;
        exp_q.push_back(32'd6);
        name_q.push_back("b2b_first");
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_first_latency", 64'(n), 64'(expLatency(2'b00, 32'd3)));
        bus.operand1 = 32'd4;
        bus.operand2 = 32'd4;
        bus.start    = 1'b1;
        exp_q.push_back(32'd16);
        name_q.push_back("b2b_second");
        @(posedge clk);
        #1;
        checkOutput("b2b_ignored_in_done", {63'b0, bus.busy}, 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("b2b_accepted", {63'b0, bus.busy}, 64'd1);
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("b2b_second_latency", 64'(n), 64'(expLatency(2'b00, 32'd4)));
        @(posedge clk);
        #1;
        last_result = 32'd16;

        // Reset mid-CALC discards the operation and clears the outputs.
        @(negedge clk);
        bus.mul_opcode = 2'b11;
        bus.operand1   = 32'hFFFFFFFF;
        bus.operand2   = 32'h80000001;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_result", {32'b0, bus.result}, 64'd0);
        checkOutput("midreset_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("midreset_done", {63'b0, bus.done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, "mulhu_after_reset", 0);

        repeat (5) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_iter_radix.md
Name: mul_iter_radix

Overview:
- Parametrised iterative multiplier for the RV32M/RV64M M-extension. Successor to the fixed 32-bit radix-2 unit.
- Generic in XLEN and in bits retired per cycle (radix 2/4/16).
- Computes MUL, MULH, MULHSU and MULHU with correct signed semantics.
- Sits in the EX stage beside the ALU. Drives `busy` to stall the pipeline and accepts `abort` on a flush.

Parameters:
- XLEN, 32, operand and result width; must be 32 or 64.
- BITS_PER_CYCLE, 1, multiplier bits consumed per CALC cycle; legal values 1, 2, 4; must divide XLEN.
- NITER, XLEN/BITS_PER_CYCLE, derived; localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mul_opcode  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- operand1  in  XLEN  rs1 (multiplicand).
- operand2  in  XLEN  rs2 (multiplier).
- abort  in  1  pipeline flush; cancels the operation in flight.
- result  out  XLEN  selected half of the product.
- done  out  1  one-cycle pulse: result valid.
- busy  out  1  high from the cycle after start is accepted until the cycle done is high (inclusive).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; result, done and busy all 0; internal registers cleared.
  - Reset asserted mid-operation discards everything; no done.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 -> CALC. Latch opcode and compute magnitudes:
  - a_neg = operand1[XLEN-1] for MULH/MULHSU, else 0.
  - b_neg = operand2[XLEN-1] for MULH only.
  - mcand = |operand1| if a_neg, else operand1.
  - mplier = |operand2| if b_neg, else operand2.
  - neg = a_neg XOR b_neg.
  - prod = 0, cnt = 0.
- CALC, each cycle:
  - prod += (mcand * mplier[BITS_PER_CYCLE-1:0]) << (cnt*BITS_PER_CYCLE).
  - mplier >>= BITS_PER_CYCLE; cnt++.
  - prod is 2*XLEN bits unsigned; partial products never overflow.
  - Leave to FIX when cnt==NITER-1 (i.e. after NITER cycles).
- FIX: prod = neg ? (~prod+1) : prod, in 2*XLEN-bit two's complement. Then -> DONE.
- DONE:
  - result = prod[XLEN-1:0] for MUL; prod[2*XLEN-1:XLEN] otherwise.
  - done=1 for exactly this cycle, then -> IDLE.
- result holds its value until the next DONE; it is not cleared on start.
- Latency: done is high on the cycle following edge NITER+2 after the sampling edge of start. XLEN=32, BITS_PER_CYCLE=1 gives 34 edges.
- Back-to-back: start may be high in the cycle done is high. It is ignored there; it is accepted the following cycle (IDLE).
- start while busy: ignored; operands are not re-latched.
- abort in CALC or FIX -> IDLE next edge; busy drops, no done, result unchanged.
- abort in DONE: too late; done still pulses.
- abort and start together in IDLE: abort wins; nothing is accepted.
- Edge values:
  - MULH of most-negative x most-negative: the magnitude path must use XLEN+1-bit absolute values so the 0x8000_0000 magnitude is exact.
  - Operand 0 follows the normal latency unless ZERO_SKIP_EN is defined.

Optional Feature:
- Macro: MUL_ITER_ZERO_SKIP_EN.
- Defined: in CALC, if the post-shift mplier==0, go to FIX immediately.
  - Latency becomes (index of highest set multiplier group)+3 edges; minimum 3 edges, e.g. operand2=0 or 1.
  - busy and done semantics are unchanged.
- Undefined: fixed latency NITER+2; no comparator is synthesised.

Test Plan:
- XLEN=32, B=1: MUL 7 x 6 -> result 0x0000002A; done exactly 34 edges after start; busy high throughout.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- Abort 10 cycles into a MUL: busy=0 next cycle, no done pulse, result keeps its prior value. A following MUL 3 x 5 returns 0x0000000F.
- Reset mid-CALC, then release and issue MULHU 0x00010000 x 0x00010000 -> 0x00000001 with standard latency.
- XLEN=64, B=4: random signed/unsigned sweep of 10k operations against a reference model. Latency 18 edges; back-to-back starts are spaced by done.
- ZERO_SKIP_EN defined: MUL 0x12345678 x 0 -> 0 after 3 edges; MUL x 0x00000100 -> done after 11 edges (B=1).
